// File: rtl/gpio_bank_pkg.sv
// Shared types and helpers for the GPIO cell bank.
package gpio_bank_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } deb_state_t;

    // Counter must hold DEBOUNCE_CYCLES-1 without wrapping.
    function automatic int cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/gpio_input_filter.sv
// One pad channel's input side: gating, synchroniser, debounce, edge pulses
// and the sticky interrupt-pending bit.
module gpio_input_filter
    import gpio_bank_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic pad_in,
    input  logic ie,
    input  logic irq_en_rise,
    input  logic irq_en_fall,
    input  logic irq_clear,
    output logic i,
    output logic rise,
    output logic fall,
    output logic irq_pending
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic                   raw;
    logic                   s;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   stable;
    deb_state_t             state;

    assign raw = ie & pad_in;
    assign s   = sync_q[SYNC_STAGES-1];
    assign i   = stable;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // A new level is accepted only after it has differed from the current
    // one for DEBOUNCE_CYCLES consecutive synchronised samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= STABLE;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                STABLE: begin
                    if (s != stable) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            stable <= s;
                            rise   <= s;
                            fall   <= ~s;
                        end else begin
                            state <= COUNT;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                COUNT: begin
                    if (s == stable) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        stable <= s;
                        rise   <= s;
                        fall   <= ~s;
                        state  <= STABLE;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // A set in the same cycle as a clear wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_pending <= 1'b0;
        end else begin
            irq_pending <= (irq_pending & ~irq_clear)
                         | (rise & irq_en_rise)
                         | (fall & irq_en_fall);
        end
    end

endmodule

// File: rtl/generic_gpio_cell_bank.sv
// Bank of WIDTH bidirectional GPIO pad channels with optional output
// registering, debounced inputs, edge detection and a merged interrupt.
module generic_gpio_cell_bank
    import gpio_bank_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int OUT_REG         = 1
) (
    input  logic             clock,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] pad,
    input  logic [WIDTH-1:0] o,
    input  logic [WIDTH-1:0] oe,
    input  logic [WIDTH-1:0] ie,
    output logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    input  logic [WIDTH-1:0] irq_en_rise,
    input  logic [WIDTH-1:0] irq_en_fall,
    input  logic [WIDTH-1:0] irq_clear,
    output logic [WIDTH-1:0] irq_pending,
    output logic             irq
);

    logic [WIDTH-1:0] o_d;
    logic [WIDTH-1:0] oe_d;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] o_q;
            logic [WIDTH-1:0] oe_q;

            // Registered drive: pad follows the core one cycle later and is
            // released (hi-Z) straight out of reset.
            always_ff @(posedge clock) begin
                if (reset) begin
                    o_q  <= '0;
                    oe_q <= '0;
                end else begin
                    o_q  <= o;
                    oe_q <= oe;
                end
            end

            assign o_d  = o_q;
            assign oe_d = oe_q;
        end else begin : g_out_comb
            assign o_d  = o;
            assign oe_d = oe;
        end
    endgenerate

    generate
        for (genvar n = 0; n < WIDTH; n++) begin : g_chan
            assign pad[n] = oe_d[n] ? o_d[n] : 1'bz;

            gpio_input_filter #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_filter (
                .clock      (clock),
                .reset      (reset),
                .pad_in     (pad[n]),
                .ie         (ie[n]),
                .irq_en_rise(irq_en_rise[n]),
                .irq_en_fall(irq_en_fall[n]),
                .irq_clear  (irq_clear[n]),
                .i          (i[n]),
                .rise       (rise[n]),
                .fall       (fall[n]),
                .irq_pending(irq_pending[n])
            );
        end
    endgenerate

    assign irq = |irq_pending;

endmodule

// File: tb/tb_generic_gpio_cell_bank.sv
// Scoreboard bench for generic_gpio_cell_bank: directed scenarios followed by
// biased random traffic, checked against a history-window reference model.
module tb_generic_gpio_cell_bank;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] o = '0, oe = '0, ie = '0;
    logic [W-1:0] irq_en_rise = '0, irq_en_fall = '0, irq_clear = '0;
    logic [W-1:0] drv_val = '0;
    logic [W-1:0] drv_en  = '1;
    wire  [W-1:0] pad;
    logic [W-1:0] i, rise, fall, irq_pending;
    logic         irq;

    generic_gpio_cell_bank #(
        .WIDTH          (W),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .OUT_REG        (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pad        (pad),
        .o          (o),
        .oe         (oe),
        .ie         (ie),
        .i          (i),
        .rise       (rise),
        .fall       (fall),
        .irq_en_rise(irq_en_rise),
        .irq_en_fall(irq_en_fall),
        .irq_clear  (irq_clear),
        .irq_pending(irq_pending),
        .irq        (irq)
    );

    for (genvar n = 0; n < W; n++) begin : g_drv
        assign pad[n] = drv_en[n] ? drv_val[n] : 1'bz;
    end

    always #5 clock = ~clock;

    // The external driver steps aside on the same edge the bank's
    // registered output enable takes over, so the pad is never contended.
    always @(posedge clock) drv_en <= reset ? '1 : ~oe;

    typedef struct packed {
        logic [W-1:0] i;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] pend;
        logic [W-1:0] pad;
        logic         irq;
    } exp_t;

    exp_t sb_q[$];

    logic [W-1:0] m_o_d = '0, m_oe_d = '0, m_stable = '0;
    logic [W-1:0] m_rise = '0, m_fall = '0, m_pend = '0;
    logic [W-1:0] raw_log[$];
    logic [W-1:0] s_log[$];

    int total = 0;
    int bad   = 0;

    // Reference: the synchronised sample is the gated pad from SYNC edges
    // ago; a channel flips when its last DEB samples all differ from i.
    task automatic applyStimulus(input logic rst, input logic [W-1:0] t_o,
                                 input logic [W-1:0] t_oe, input logic [W-1:0] t_ie,
                                 input logic [W-1:0] t_drv, input logic [W-1:0] t_enr,
                                 input logic [W-1:0] t_enf, input logic [W-1:0] t_clr);
        logic [W-1:0] pad_now, raw, s, acc;
        exp_t         e;
        int           k;
        logic         all_diff;
        @(negedge clock);
        reset       = rst;
        o           = t_o;
        oe          = t_oe;
        ie          = t_ie;
        drv_val     = t_drv;
        irq_en_rise = t_enr;
        irq_en_fall = t_enf;
        irq_clear   = t_clr;
        if (rst) begin
            raw_log.delete();
            s_log.delete();
            m_o_d = '0; m_oe_d = '0; m_stable = '0;
            m_rise = '0; m_fall = '0; m_pend = '0;
        end else begin
            pad_now = (m_oe_d & m_o_d) | (~m_oe_d & t_drv);
            raw     = t_ie & pad_now;
            raw_log.push_back(raw);
            k = raw_log.size() - 1;
            s = (k >= SYNC) ? raw_log[k-SYNC] : '0;
            s_log.push_back(s);
            acc = '0;
            if (k + 1 >= DEB) begin
                for (int n = 0; n < W; n++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < DEB; j++)
                        if (s_log[k-j][n] == m_stable[n]) all_diff = 1'b0;
                    acc[n] = all_diff;
                end
            end
            m_pend   = (m_pend & ~t_clr) | (m_rise & t_enr) | (m_fall & t_enf);
            m_rise   = acc & ~m_stable;
            m_fall   = acc & m_stable;
            m_stable = m_stable ^ acc;
            m_o_d    = t_o;
            m_oe_d   = t_oe;
        end
        e.i    = m_stable;
        e.rise = m_rise;
        e.fall = m_fall;
        e.pend = m_pend;
        e.pad  = (m_oe_d & m_o_d) | (~m_oe_d & t_drv);
        e.irq  = |m_pend;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] act,
                               input logic [W-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    exp_t mon_e;

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                checkOutput("i", i, mon_e.i);
                checkOutput("rise", rise, mon_e.rise);
                checkOutput("fall", fall, mon_e.fall);
                checkOutput("irq_pending", irq_pending, mon_e.pend);
                checkOutput("pad", pad, mon_e.pad);
                checkOutput("irq", {{(W-1){1'b0}}, irq}, {{(W-1){1'b0}}, mon_e.irq});
            end
        end
    end

    function automatic logic [W-1:0] rareMask(input int den);
        logic [W-1:0] m;
        for (int n = 0; n < W; n++) m[n] = ($urandom_range(den - 1) == 0);
        return m;
    endfunction

    logic [W-1:0] r_o, r_oe, r_ie, r_drv, r_enr, r_enf;

    initial begin
        $display("[TB] starting");
        repeat (2) applyStimulus(1'b1, '0, '0, '0, '0, '0, '0, '0);

        // Idle pads, then core drives A5 through the output register.
        repeat (3) applyStimulus(1'b0, '0, '0, '0, W'($urandom), '0, '0, '0);
        repeat (3) applyStimulus(1'b0, 8'hA5, 8'hFF, '0, '0, '0, '0, '0);
        repeat (8) applyStimulus(1'b0, '0, '0, 8'hFF, '0, '0, '0, '0);

        // Clean step on channel 0.
        repeat (10) applyStimulus(1'b0, '0, '0, 8'hFF, 8'h01, '0, '0, '0);

        // Channel 1: 3-cycle glitch rejected, 4-cycle pulse accepted.
        repeat (3) applyStimulus(1'b0, '0, '0, 8'hFF, 8'h03, '0, '0, '0);
        repeat (8) applyStimulus(1'b0, '0, '0, 8'hFF, 8'h01, '0, '0, '0);
        repeat (4) applyStimulus(1'b0, '0, '0, 8'hFF, 8'h03, '0, '0, '0);
        repeat (10) applyStimulus(1'b0, '0, '0, 8'hFF, 8'h01, '0, '0, '0);

        // Channel 2 interrupt: set, then set coinciding with clear, then clear.
        repeat (8) applyStimulus(1'b0, '0, '0, 8'hFF, 8'h05, 8'h04, '0, '0);
        repeat (8) applyStimulus(1'b0, '0, '0, 8'hFF, 8'h01, 8'h04, '0, '0);
        repeat (8) applyStimulus(1'b0, '0, '0, 8'hFF, 8'h05, 8'h04, '0, 8'h04);
        repeat (3) applyStimulus(1'b0, '0, '0, 8'hFF, 8'h05, 8'h04, '0, '0);
        repeat (2) applyStimulus(1'b0, '0, '0, 8'hFF, 8'h05, 8'h04, '0, 8'h04);

        // Channel 3 held high, reset lands mid-count.
        repeat (4) applyStimulus(1'b0, '0, '0, 8'hFF, 8'h0D, '0, '0, '0);
        applyStimulus(1'b1, '0, '0, 8'hFF, 8'h0D, '0, '0, '0);
        repeat (10) applyStimulus(1'b0, '0, '0, 8'hFF, 8'h0D, '0, '0, '0);

        // Channel 4 loopback.
        repeat (3) applyStimulus(1'b0, '0, 8'h10, 8'hFF, 8'h0D, '0, '0, '0);
        repeat (10) applyStimulus(1'b0, 8'h10, 8'h10, 8'hFF, 8'h0D, '0, '0, '0);

        // Biased random traffic: slow-changing levels so many survive debounce.
        r_o = 8'h10; r_oe = 8'h10; r_ie = 8'hFF; r_drv = 8'h0D;
        r_enr = W'($urandom); r_enf = W'($urandom);
        for (int c = 0; c < 2500; c++) begin
            r_o   ^= rareMask(5);
            r_drv ^= rareMask(5);
            r_oe  ^= rareMask(40);
            r_ie  ^= rareMask(60);
            r_enr ^= rareMask(50);
            r_enf ^= rareMask(50);
            applyStimulus(($urandom_range(299) == 0), r_o, r_oe, r_ie, r_drv,
                          r_enr, r_enf, rareMask(8));
        end

        for (int c = 0; c < 20 && sb_q.size() > 0; c++) @(posedge clock);
        #2;
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
